// File: rtl/datapath_controller.sv
// datapath_controller: Moore FSM sequencing the register-file/ALU datapath,
// one instruction at a time, with a retired-instruction counter.
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN (unsupported instructions trap
// with a sticky illegal flag instead of retiring as a NOP).
//
// state   | meaning
// --------+---------------------------------------------------------
// WAIT    | idle, w=1, accepts s and latches opcode/op
// DECODE  | branch on latched opcode/op
// GET_A   | load A from Rn (nsel=00)
// GET_B   | load B from Rm (nsel=10)
// ALU     | load C (or status flags for CMP); asel=1 for MOV Rd,Rm
// WR_REG  | write C to Rd (nsel=01, vsel=00)
// WR_IMM  | write sximm8 to Rn (nsel=00, vsel=10)
// TRAP    | parked after an unsupported instruction until reset
module datapath_controller #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             s,
  input  logic [2:0]       opcode,
  input  logic [1:0]       op,
  output logic             w,
  output logic [1:0]       nsel,
  output logic             loada,
  output logic             loadb,
  output logic             loadc,
  output logic             loads,
  output logic             asel,
  output logic             bsel,
  output logic [1:0]       vsel,
  output logic             write,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [2:0] S_WAIT   = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_GET_A  = 3'd2;
  localparam logic [2:0] S_GET_B  = 3'd3;
  localparam logic [2:0] S_ALU    = 3'd4;
  localparam logic [2:0] S_WR_REG = 3'd5;
  localparam logic [2:0] S_WR_IMM = 3'd6;
  localparam logic [2:0] S_TRAP   = 3'd7;

  localparam logic [4:0] OP_MOV_IMM = 5'b110_10;
  localparam logic [4:0] OP_MOV_REG = 5'b110_00;
  localparam logic [4:0] OP_ADD     = 5'b101_00;
  localparam logic [4:0] OP_CMP     = 5'b101_01;
  localparam logic [4:0] OP_AND     = 5'b101_10;
  localparam logic [4:0] OP_MVN     = 5'b101_11;

  logic [2:0]       state_q, state_d;
  logic [4:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire;

  // Next-state logic; opcode/op are only looked at while idle in WAIT.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      S_WAIT: begin
        if (s) begin
          state_d = S_DECODE;
          op_d    = {opcode, op};
        end
      end
      S_DECODE: begin
        case (op_q)
          OP_MOV_IMM:                 state_d = S_WR_IMM;
          OP_MOV_REG, OP_MVN:         state_d = S_GET_B;
          OP_ADD, OP_AND, OP_CMP:     state_d = S_GET_A;
`ifdef CTRL_ILLEGAL_TRAP_EN
          default:                    state_d = S_TRAP;
`else
          default:                    state_d = S_WAIT;
`endif
        endcase
      end
      S_GET_A:  state_d = S_GET_B;
      S_GET_B:  state_d = S_ALU;
      S_ALU:    state_d = (op_q == OP_CMP) ? S_WAIT : S_WR_REG;
      S_WR_REG: state_d = S_WAIT;
      S_WR_IMM: state_d = S_WAIT;
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_TRAP:   state_d = S_TRAP;
`else
      S_TRAP:   state_d = S_WAIT;
`endif
      default:  state_d = S_WAIT;
    endcase
  end

  // Count retirements: entry to WAIT from a final state (TRAP recovery excluded).
  always_comb begin
    retire = (state_d == S_WAIT) &&
             ((state_q == S_DECODE) || (state_q == S_ALU) ||
              (state_q == S_WR_REG) || (state_q == S_WR_IMM));
    cnt_d  = retire ? cnt_q + CNT_W'(1) : cnt_q;
  end

  // State, latched instruction and counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_WAIT;
      op_q    <= 5'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;

  // Sticky flag set on entry to TRAP, cleared only by reset.
  always_comb illegal_d = illegal_q | (state_d == S_TRAP);

  // Illegal flag register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) illegal_q <= 1'b0;
    else          illegal_q <= illegal_d;
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  assign instr_count = cnt_q;

  // Moore output decode from the registered state and latched instruction.
  always_comb begin
    w     = 1'b0;
    nsel  = 2'b00;
    loada = 1'b0;
    loadb = 1'b0;
    loadc = 1'b0;
    loads = 1'b0;
    asel  = 1'b0;
    bsel  = 1'b0;
    vsel  = 2'b00;
    write = 1'b0;
    case (state_q)
      S_WAIT:   w = 1'b1;
      S_GET_A:  loada = 1'b1;
      S_GET_B: begin
        nsel  = 2'b10;
        loadb = 1'b1;
      end
      S_ALU: begin
        loadc = (op_q != OP_CMP);
        loads = (op_q == OP_CMP);
        asel  = (op_q == OP_MOV_REG);
      end
      S_WR_REG: begin
        nsel  = 2'b01;
        write = 1'b1;
      end
      S_WR_IMM: begin
        vsel  = 2'b10;
        write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
